key_event_detect: RTL and testbench

KEY_EVENT_DETECT -- requirements
Module: key_event_detect

---
 rtl/key_event_detect.sv | 195 +++++++++++++++++++
 tb/tb_key_event_detect.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/key_event_detect.sv
// key_event_detect
//   Per-channel key debouncer and event generator. Each raw key pin is
//   synchronised, polarity-normalised, debounced, and turned into
//   press / release / long-hold / auto-repeat single-cycle pulses.
//
//   Optional feature: define KEY_REPEAT_EN to enable auto-repeat pulses
//   while a key is long-held; otherwise key_repeat is tied to 0.
//
// Ports
//   clk          : system clock, rising edge
//   rst_n        : asynchronous active-low reset
//   key_in       : [KEY_NUM] raw asynchronous key pins
//   key_level    : [KEY_NUM] debounced state, 1 = pressed
//   key_press    : [KEY_NUM] one-cycle pulse on debounced press
//   key_release  : [KEY_NUM] one-cycle pulse on debounced release
//   key_long     : [KEY_NUM] one-cycle pulse when hold reaches LONG_CYCLES
//   key_repeat   : [KEY_NUM] one-cycle pulse every REPEAT_CYCLES while long-held
module key_event_detect #(
  parameter int KEY_NUM       = 4,
  parameter int ACTIVE_LOW    = 1,
  parameter int DB_CYCLES     = 1_000_000,
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_level,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long,
  output logic [KEY_NUM-1:0] key_repeat
);

  localparam int DB_W   = $clog2(DB_CYCLES) + 1;
  localparam int HOLD_W = $clog2(LONG_CYCLES) + 1;
  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DB_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES - 1);
  // Pin level when the key is not pressed.
  localparam logic REL_LVL = (ACTIVE_LOW != 0);

  typedef enum logic [2:0] {
    IDLE, PRESS_DB, HELD, LONG, RELEASE_DB
  } state_t;

  logic [KEY_NUM-1:0] r_sync1, r_sync2;
  logic [KEY_NUM-1:0] w_pressed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= {KEY_NUM{REL_LVL}};
      r_sync2 <= {KEY_NUM{REL_LVL}};
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pressed = r_sync2 ^ {KEY_NUM{REL_LVL}};

  for (genvar g = 0; g < KEY_NUM; g++) begin : g_ch
    state_t            r_state, w_state_nxt;
    logic [DB_W-1:0]   r_db, w_db_nxt;
    logic [HOLD_W-1:0] r_hold, w_hold_nxt;
    // r_entry marks the first cycle after a pulse-worthy transition; returns
    // from RELEASE_DB and aborted press debounces never set it.
    logic              r_entry, w_entry_nxt;
    logic              r_ret_long, w_ret_long_nxt;
    logic              w_level, w_press, w_release, w_long;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state    <= IDLE;
        r_db       <= '0;
        r_hold     <= '0;
        r_entry    <= 1'b0;
        r_ret_long <= 1'b0;
      end else begin
        r_state    <= w_state_nxt;
        r_db       <= w_db_nxt;
        r_hold     <= w_hold_nxt;
        r_entry    <= w_entry_nxt;
        r_ret_long <= w_ret_long_nxt;
      end
    end

    always_comb begin
      w_state_nxt    = r_state;
      w_db_nxt       = r_db;
      w_hold_nxt     = r_hold;
      w_entry_nxt    = 1'b0;
      w_ret_long_nxt = r_ret_long;
      case (r_state)
        IDLE: begin
          if (w_pressed[g]) begin
            w_state_nxt = PRESS_DB;
            w_db_nxt    = '0;
          end
        end
        PRESS_DB: begin
          if (!w_pressed[g]) begin
            w_state_nxt = IDLE;
          end else if (r_db == DB_MAX) begin
            w_state_nxt = HELD;
            w_hold_nxt  = '0;
            w_entry_nxt = 1'b1;
          end else begin
            w_db_nxt = r_db + 1'b1;
          end
        end
        HELD: begin
          if (!w_pressed[g]) begin
            w_state_nxt    = RELEASE_DB;
            w_db_nxt       = '0;
            w_ret_long_nxt = 1'b0;
          end else if (r_hold == HOLD_MAX) begin
            w_state_nxt = LONG;
            w_entry_nxt = 1'b1;
          end else begin
            w_hold_nxt = r_hold + 1'b1;
          end
        end
        LONG: begin
          if (!w_pressed[g]) begin
            w_state_nxt    = RELEASE_DB;
            w_db_nxt       = '0;
            w_ret_long_nxt = 1'b1;
          end
        end
        RELEASE_DB: begin
          if (w_pressed[g]) begin
            w_state_nxt = r_ret_long ? LONG : HELD;
          end else if (r_db == DB_MAX) begin
            w_state_nxt = IDLE;
            w_entry_nxt = 1'b1;
          end else begin
            w_db_nxt = r_db + 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end

    always_comb begin
      w_level   = (r_state == HELD) || (r_state == LONG) || (r_state == RELEASE_DB);
      w_press   = (r_state == HELD) && r_entry;
      w_long    = (r_state == LONG) && r_entry;
      w_release = (r_state == IDLE) && r_entry;
    end

    assign key_level[g]   = w_level;
    assign key_press[g]   = w_press;
    assign key_long[g]    = w_long;
    assign key_release[g] = w_release;

`ifdef KEY_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES) + 1;
    localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] r_rep, w_rep_nxt;
    logic             r_rep_pulse, w_rep_pulse_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rep       <= '0;
        r_rep_pulse <= 1'b0;
      end else begin
        r_rep       <= w_rep_nxt;
        r_rep_pulse <= w_rep_pulse_nxt;
      end
    end

    // Counter frozen while in RELEASE_DB; restarts only on HELD->LONG.
    always_comb begin
      w_rep_nxt       = r_rep;
      w_rep_pulse_nxt = 1'b0;
      if (r_state == HELD && w_state_nxt == LONG) begin
        w_rep_nxt = '0;
      end else if (r_state == LONG && w_pressed[g]) begin
        if (r_rep == REP_MAX) begin
          w_rep_nxt       = '0;
          w_rep_pulse_nxt = 1'b1;
        end else begin
          w_rep_nxt = r_rep + 1'b1;
        end
      end
    end

    assign key_repeat[g] = (r_state == LONG) && r_rep_pulse;
`else
    assign key_repeat[g] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_key_event_detect.sv
module tb_key_event_detect;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_in;
  logic [3:0] key_level, key_press, key_release, key_long, key_repeat;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef KEY_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  key_event_detect #(
    .KEY_NUM      (4),
    .ACTIVE_LOW   (1),
    .DB_CYCLES    (4),
    .LONG_CYCLES  (20),
    .REPEAT_CYCLES(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long),
    .key_repeat (key_repeat)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_press, input logic [3:0] e_rel,
                         input logic [3:0] e_long, input logic [3:0] e_rep, input logic [3:0] e_lvl);
    chk({tag, ".press"},   key_press,   e_press);
    chk({tag, ".release"}, key_release, e_rel);
    chk({tag, ".long"},    key_long,    e_long);
    chk({tag, ".repeat"},  key_repeat,  e_rep);
    chk({tag, ".level"},   key_level,   e_lvl);
  endtask

  initial begin
    logic [3:0] ep, er, el, erp, elv;

    // Reset state
    rst_n  = 1'b0;
    key_in = 4'b1111;
    #2;
    chk_all("reset_async", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("reset_hold[%0d]", i), 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("post_reset[%0d]", i), 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    end

    // Single clean press on key 0, held 10 cycles, then release
    key_in[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      ep  = (i == 7) ? 4'b0001 : 4'b0000;
      elv = (i >= 7) ? 4'b0001 : 4'b0000;
      chk_all($sformatf("k0_press[%0d]", i), ep, 4'h0, 4'h0, 4'h0, elv);
    end
    key_in[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      er  = (i == 7) ? 4'b0001 : 4'b0000;
      elv = (i < 7)  ? 4'b0001 : 4'b0000;
      chk_all($sformatf("k0_release[%0d]", i), 4'h0, er, 4'h0, 4'h0, elv);
    end

    // Bouncing key 1: 3 cycles low / 3 high, five times
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 6; i++) begin
        key_in[1] = (i < 3) ? 1'b0 : 1'b1;
        tick();
        chk_all($sformatf("k1_bounce[%0d.%0d]", r, i), 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_all($sformatf("k1_settle[%0d]", i), 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    end

    // Key 2 held 60 cycles: press, long, auto-repeat, then release
    key_in[2] = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      ep  = (i == 7)  ? 4'b0100 : 4'b0000;
      el  = (i == 27) ? 4'b0100 : 4'b0000;
      erp = (REP_EN && i > 27 && ((i - 27) % 8) == 0) ? 4'b0100 : 4'b0000;
      elv = (i >= 7)  ? 4'b0100 : 4'b0000;
      chk_all($sformatf("k2_hold[%0d]", i), ep, 4'h0, el, erp, elv);
    end
    key_in[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      er  = (i == 7) ? 4'b0100 : 4'b0000;
      elv = (i < 7)  ? 4'b0100 : 4'b0000;
      chk_all($sformatf("k2_release[%0d]", i), 4'h0, er, 4'h0, 4'h0, elv);
    end

    // Key 0 held, 2-cycle high glitch; glitch costs 3 hold cycles -> long at 30
    key_in[0] = 1'b0;
    for (int i = 0; i < 35; i++) begin
      tick();
      ep  = (i == 7)  ? 4'b0001 : 4'b0000;
      el  = (i == 30) ? 4'b0001 : 4'b0000;
      elv = (i >= 7)  ? 4'b0001 : 4'b0000;
      chk_all($sformatf("k0_glitch[%0d]", i), ep, 4'h0, el, 4'h0, elv);
      if (i == 11) key_in[0] = 1'b1;
      if (i == 13) key_in[0] = 1'b0;
    end
    key_in[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      er  = (i == 7) ? 4'b0001 : 4'b0000;
      elv = (i < 7)  ? 4'b0001 : 4'b0000;
      chk_all($sformatf("k0_glitch_rel[%0d]", i), 4'h0, er, 4'h0, 4'h0, elv);
    end

    // Keys 0 and 3 pressed in the same cycle
    key_in = 4'b0110;
    for (int i = 0; i < 10; i++) begin
      tick();
      ep  = (i == 7) ? 4'b1001 : 4'b0000;
      elv = (i >= 7) ? 4'b1001 : 4'b0000;
      chk_all($sformatf("k03_press[%0d]", i), ep, 4'h0, 4'h0, 4'h0, elv);
    end
    key_in = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      tick();
      er  = (i == 7) ? 4'b1001 : 4'b0000;
      elv = (i < 7)  ? 4'b1001 : 4'b0000;
      chk_all($sformatf("k03_release[%0d]", i), 4'h0, er, 4'h0, 4'h0, elv);
    end

    // Reset while key 2 is in LONG; key stays held through and after reset
    key_in[2] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      ep  = (i == 7)  ? 4'b0100 : 4'b0000;
      el  = (i == 27) ? 4'b0100 : 4'b0000;
      elv = (i >= 7)  ? 4'b0100 : 4'b0000;
      chk_all($sformatf("k2_prerst[%0d]", i), ep, 4'h0, el, 4'h0, elv);
    end
    rst_n = 1'b0;
    #1;
    chk_all("k2_rst_immediate", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_all($sformatf("k2_rst_hold[%0d]", i), 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      ep  = (i == 7) ? 4'b0100 : 4'b0000;
      elv = (i >= 7) ? 4'b0100 : 4'b0000;
      chk_all($sformatf("k2_postrst[%0d]", i), ep, 4'h0, 4'h0, 4'h0, elv);
    end
    key_in[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      er  = (i == 7) ? 4'b0100 : 4'b0000;
      elv = (i < 7)  ? 4'b0100 : 4'b0000;
      chk_all($sformatf("k2_postrst_rel[%0d]", i), 4'h0, er, 4'h0, 4'h0, elv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
